// File: rtl/req_encoder_4to2.sv
// Sequential 4-to-2 encoder: synchronizes active-low requests, latches falling edges as
// sticky pending bits and issues them one at a time on a valid/ack handshake.
// Optional macro ROUND_ROBIN_EN rotates grant priority; default is fixed lowest-index-first.
module req_encoder_4to2 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_n,
  output logic       a0,
  output logic       a1,
  output logic       valid,
  input  logic       ack,
  output logic [3:0] pending,
  output logic       multi
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  logic [NREQ-1:0] sync_q [SYNC_STAGES];
  logic [NREQ-1:0] sync_d [SYNC_STAGES];
  logic [NREQ-1:0] hist_q, hist_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            multi_q, multi_d;
  state_e          state_q, state_d;
  logic [NREQ-1:0] fall_c;
  logic [NREQ-1:0] clr_c;
  logic [IW-1:0]   start_c;
  logic [IW-1:0]   sel_c;

`ifdef ROUND_ROBIN_EN
  logic [IW-1:0]   last_q, last_d;
  assign start_c = IW'(last_q + IW'(1));
`else
  assign start_c = '0;
`endif

  // First set bit of p found when scanning upward from start, wrapping 3->0.
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] p, input logic [IW-1:0] start);
    logic [IW-1:0] c;
    pick = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = IW'(start + IW'(k));
      if (p[c]) pick = c;
    end
  endfunction

  always_comb begin
    sync_d[0] = req_n;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    hist_d = sync_q[SYNC_STAGES-1];
    fall_c = hist_q & ~sync_q[SYNC_STAGES-1];
  end

  assign sel_c = pick(pending_q, start_c);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    multi_d = multi_q;
    clr_c   = '0;
`ifdef ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pending_q != '0) begin
          idx_d   = sel_c;
          multi_d = ($countones(pending_q) > 1);
          valid_d = 1'b1;
          state_d = GRANT;
`ifdef ROUND_ROBIN_EN
          last_d  = sel_c;
`endif
        end
      end
      GRANT: begin
        if (ack) begin
          clr_c   = NREQ'(1) << idx_q;
          valid_d = 1'b0;
          multi_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the bit being cleared must survive the clear.
    pending_d = (pending_q & ~clr_c) | fall_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      hist_q    <= '1;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
      state_q   <= IDLE;
`ifdef ROUND_ROBIN_EN
      last_q    <= '1;
`endif
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      hist_q    <= hist_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      multi_q   <= multi_d;
      state_q   <= state_d;
`ifdef ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  assign a0      = idx_q[0];
  assign a1      = idx_q[1];
  assign valid   = valid_q;
  assign multi   = multi_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Directed bench for req_encoder_4to2 (SYNC_STAGES=2) with hand-computed expectations.
module tb_req_encoder_4to2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_n;
  logic       a0, a1, valid, ack, multi;
  logic [3:0] pending;
  int         n_checks;
  int         n_errors;

  req_encoder_4to2 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .a0(a0), .a1(a1),
    .valid(valid), .ack(ack), .pending(pending), .multi(multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!valid && n < 30) begin
      step();
      n++;
    end
    check(tag, 8'(valid), 8'd1);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int cnt [4];
    int back2back;
    int grants;
    logic prev_valid;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    req_n = 4'b1111;
    ack   = 1'b0;
    #3;
    check("rst_valid", 8'(valid), 8'd0);
    check("rst_pending", 8'(pending), 8'h0);
    check("rst_idx", 8'({a1, a0}), 8'd0);
    check("rst_multi", 8'(multi), 8'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single request on bit 2 with exact capture and grant latency
    req_n[2] = 1'b0;
    step();
    check("t1_pend_e", 8'(pending), 8'h0);
    step();
    check("t1_pend_e1", 8'(pending), 8'h0);
    step();
    check("t1_pend_e2", 8'(pending), 8'h4);
    check("t1_valid_early", 8'(valid), 8'd0);
    step();
    check("t1_valid", 8'(valid), 8'd1);
    check("t1_idx", 8'({a1, a0}), 8'd2);
    check("t1_multi", 8'(multi), 8'd0);
    ack_pulse();
    check("t1_ack_pend", 8'(pending), 8'h0);
    check("t1_ack_valid", 8'(valid), 8'd0);
    steps(3);
    check("t1_level_hold", 8'(pending), 8'h0);
    check("t1_level_valid", 8'(valid), 8'd0);
    req_n = 4'b1111;
    steps(4);

    // Simultaneous bits 0 and 3
    req_n = 4'b0110;
    steps(3);
    check("t2_pend", 8'(pending), 8'h9);
    step();
    check("t2_g1_idx", 8'({a1, a0}), 8'd0);
    check("t2_g1_multi", 8'(multi), 8'd1);
    ack_pulse();
    check("t2_gap_valid", 8'(valid), 8'd0);
    check("t2_gap_pend", 8'(pending), 8'h8);
    check("t2_gap_idx_hold", 8'({a1, a0}), 8'd0);
    step();
    check("t2_g2_valid", 8'(valid), 8'd1);
    check("t2_g2_idx", 8'({a1, a0}), 8'd3);
    check("t2_g2_multi", 8'(multi), 8'd0);
    ack_pulse();
    check("t2_done_pend", 8'(pending), 8'h0);
    req_n = 4'b1111;
    steps(4);

    // ack held high, staggered requests on 1, 3, 0
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    back2back = 0;
    grants = 0;
    prev_valid = 1'b0;
    ack = 1'b1;
    req_n[1] = 1'b0;
    step();
    req_n[3] = 1'b0;
    step();
    req_n[0] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (valid) begin
        if (prev_valid) back2back++;
        cnt[{a1, a0}]++;
        grants++;
      end
      prev_valid = valid;
    end
    check("t3_grants", 8'(grants), 8'd3);
    check("t3_cnt0", 8'(cnt[0]), 8'd1);
    check("t3_cnt1", 8'(cnt[1]), 8'd1);
    check("t3_cnt3", 8'(cnt[3]), 8'd1);
    check("t3_back2back", 8'(back2back), 8'd0);
    check("t3_pend", 8'(pending), 8'h0);
    ack = 1'b0;
    req_n = 4'b1111;
    steps(4);

    // Re-request landing exactly on the ack edge of the same index
    req_n[1] = 1'b0;
    wait_valid("t4_wait1");
    check("t4_idx1", 8'({a1, a0}), 8'd1);
    req_n[1] = 1'b1;
    steps(3);
    req_n[1] = 1'b0;
    steps(2);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t4_set_wins", 8'(pending), 8'h2);
    check("t4_ack_valid", 8'(valid), 8'd0);
    step();
    check("t4_regrant_valid", 8'(valid), 8'd1);
    check("t4_regrant_idx", 8'({a1, a0}), 8'd1);
    ack_pulse();
    check("t4_done_pend", 8'(pending), 8'h0);
    req_n = 4'b1111;
    steps(4);

    // Held-low request through reset, then reset mid-grant
    req_n = 4'b1110;
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    wait_valid("t5_wait1");
    check("t5_idx1", 8'({a1, a0}), 8'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 8'(valid), 8'd0);
    check("t5_rst_pend", 8'(pending), 8'h0);
    check("t5_rst_multi", 8'(multi), 8'd0);
    step();
    rst_n = 1'b1;
    wait_valid("t5_wait2");
    check("t5_idx2", 8'({a1, a0}), 8'd0);
    check("t5_pend2", 8'(pending), 8'h1);
    ack_pulse();
    check("t5_done_pend", 8'(pending), 8'h0);
    req_n = 4'b1111;
    steps(4);

    // All four fall together: priority order
    req_n = 4'b0000;
    wait_valid("t6_wait0");
    check("t6_first_idx", 8'({a1, a0}), 8'd0);
    check("t6_first_multi", 8'(multi), 8'd1);
`ifdef ROUND_ROBIN_EN
    for (int e = 1; e < 4; e++) begin
      ack_pulse();
      wait_valid("t6_rr_wait");
      check("t6_rr_idx", 8'({a1, a0}), 8'(e));
    end
    ack_pulse();
`else
    for (int k = 0; k < 3; k++) begin
      req_n[0] = 1'b1;
      steps(3);
      req_n[0] = 1'b0;
      steps(2);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("t6_bit0_rearm", 8'(pending[0]), 8'd1);
      step();
      check("t6_bit0_first", 8'({a1, a0}), 8'd0);
      check("t6_bit0_valid", 8'(valid), 8'd1);
    end
    ack_pulse();
    for (int e = 1; e < 4; e++) begin
      wait_valid("t6_fix_wait");
      check("t6_fix_idx", 8'({a1, a0}), 8'(e));
      ack_pulse();
    end
`endif
    check("t6_done_pend", 8'(pending), 8'h0);
    req_n = 4'b1111;
    steps(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
